// File: rtl/mm_tile_sched.sv
// Tile-level sequencer for the systolic matrix-multiply datapath: walks the
// MxM output one N1xN2 tile at a time through load, clear, compute and store.
//
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | operand load requested, waiting for ld_ack
//   CLR    | one-cycle accumulator clear
//   COMP   | array enabled for CW cycles
//   STORE  | tile results to D banks, waiting for st_ack
//   DRAIN  | one-cycle drain_start pulse
//   WAIT_D | waiting for the drain path to report the final beat
module mm_tile_sched #(
   parameter int M  = 8,
   parameter int N1 = 4,
   parameter int N2 = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     ld_req,
   output logic                     ld_a_en,
   output logic [$clog2(M)-1:0]     ld_row_base,
   output logic [$clog2(M)-1:0]     ld_col_base,
   input  logic                     ld_ack,
   output logic                     acc_clr,
   output logic                     comp_en,
   output logic                     st_req,
   output logic [$clog2(M*M)-1:0]   st_base,
   input  logic                     st_ack,
   output logic                     drain_start,
   input  logic                     drain_done,
   output logic                     job_done
);

   localparam int TR  = M / N1;
   localparam int TC  = M / N2;
   localparam int CW  = M + N1 + N2 - 2;
   localparam int RBW = $clog2(M);
   localparam int SBW = $clog2(M*M);
   localparam int TIW = (TR > 1) ? $clog2(TR) : 1;
   localparam int TJW = (TC > 1) ? $clog2(TC) : 1;
   localparam int CNW = $clog2(CW + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, CLR, COMP, STORE, DRAIN, WAIT_D
   } state_t;

   state_t           state;
   logic [TIW-1:0]   ti;
   logic [TJW-1:0]   tj;
   logic [CNW-1:0]   cnt;

   logic             last_ti;
   logic             last_tj;
   logic [TIW-1:0]   nxt_ti;
   logic [TJW-1:0]   nxt_tj;

   // Row-major tile walk: tj advances fastest, wrapping into ti.
   always_comb begin
      last_ti = (ti == TIW'(TR - 1));
      last_tj = (tj == TJW'(TC - 1));
      nxt_tj  = last_tj ? '0 : tj + 1'b1;
      nxt_ti  = last_tj ? ti + 1'b1 : ti;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ti          <= '0;
         tj          <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         ld_req      <= 1'b0;
         ld_a_en     <= 1'b0;
         ld_row_base <= '0;
         ld_col_base <= '0;
         acc_clr     <= 1'b0;
         comp_en     <= 1'b0;
         st_req      <= 1'b0;
         st_base     <= '0;
         drain_start <= 1'b0;
         job_done    <= 1'b0;
      end else begin
         acc_clr     <= 1'b0;
         drain_start <= 1'b0;
         job_done    <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state       <= LOAD;
               busy        <= 1'b1;
               ld_req      <= 1'b1;
               ld_a_en     <= 1'b1;
               ti          <= '0;
               tj          <= '0;
               ld_row_base <= '0;
               ld_col_base <= '0;
               st_base     <= '0;
            end
            LOAD: if (ld_ack) begin
               state   <= CLR;
               ld_req  <= 1'b0;
               ld_a_en <= 1'b0;
               acc_clr <= 1'b1;
            end
            CLR: begin
               state   <= COMP;
               comp_en <= 1'b1;
               cnt     <= '0;
            end
            COMP: if (cnt == CNW'(CW - 1)) begin
               state   <= STORE;
               comp_en <= 1'b0;
               cnt     <= '0;
               st_req  <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
            STORE: if (st_ack) begin
               st_req <= 1'b0;
               if (last_ti && last_tj) begin
                  state       <= DRAIN;
                  drain_start <= 1'b1;
               end else begin
                  // Bases are latched here so they hold for the whole next tile.
                  state       <= LOAD;
                  ti          <= nxt_ti;
                  tj          <= nxt_tj;
                  ld_req      <= 1'b1;
                  ld_a_en     <= last_tj;
                  ld_row_base <= RBW'(int'(nxt_ti) * N1);
                  ld_col_base <= RBW'(int'(nxt_tj) * N2);
                  st_base     <= SBW'(int'(nxt_ti) * N1 * M + int'(nxt_tj) * N2);
               end
            end
            DRAIN: state <= WAIT_D;
            WAIT_D: if (drain_done) begin
               state    <= IDLE;
               busy     <= 1'b0;
               job_done <= 1'b1;
               ti       <= '0;
               tj       <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
